multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
- Parametrised multicycle control sequencer for the RV32I core.
- Drives the core's control-signal bundle: register-file, PC, IR and CSR write enables, memory request strobes, and datapath mux selects.
- Generalises the flat control bundle with:
  - a configurable memory-timeout watchdog;
  - precise trap generation with cause codes;
  - a debug halt/resume handshake taken only at instruction boundaries.
- Sits between the decoder/datapath status signals and the datapath.

Parameters:
- OPCODE_WIDTH, 7, opcode field width.
- F3_WIDTH, 3, funct3 field width.
- MEM_TIMEOUT, 16, cycles to wait for mem_complete_* before raising an access fault; 0 disables the watchdog.
- HALT_ON_RESET, 0, if 1 the reset state is HALTED instead of FETCH.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- opcode  in  OPCODE_WIDTH  IR opcode field
- f3  in  F3_WIDTH  IR funct3 field
- invalid_inst  in  1  decoder: illegal encoding
- ialign  in  1  target PC misaligned (qualified by datapath for taken branch/jump)
- invalid_csr  in  1  CSR address/access illegal
- mem_malign  in  1  data address misaligned for current f3
- mem_complete_read  in  1  read data valid this cycle
- mem_complete_write  in  1  write accepted this cycle
- halt_req  in  1  debug halt request (level)
- resume_req  in  1  debug resume request (level)
- write_pc, write_ir, write_rd, write_csr  out  1 each  write enables
- mem_read, mem_write  out  1 each  memory request strobes
- addr_sel  out  1  0=PC, 1=ALU result
- rd_sel  out  2  0=ALU, 1=MEM, 2=PC+4, 3=CSR
- alu_insel1  out  2  0=rs1, 1=PC, 2=zero
- alu_insel2  out  2  0=rs2, 1=imm, 2=const 4
- trap  out  1  trap-entry pulse
- trap_cause  out  4  registered mcause code, valid while trap=1
- halted  out  1  core in debug halt

Behaviour:
- States: FETCH, DECODE, EXECUTE, MEM, TRAP, HALTED. State register is 3 bits.
- Outputs are combinational from state, opcode, f3 and status inputs. trap_cause is a register.
- Reset: state=FETCH (HALTED if HALT_ON_RESET), timeout counter=0, trap_cause=0.
  - All enables/strobes are 0 in the reset cycle; selects are 0.
  - Reset mid-memory-access drops the request the same cycle.
- Instruction boundary: every transition that would enter FETCH goes to HALTED instead if halt_req=1 at that edge.
- FETCH:
  - mem_read=1, addr_sel=0.
  - On mem_complete_read: write_ir=1, next DECODE.
  - On watchdog expiry: trap_cause=1, next TRAP.
- DECODE (1 cycle, no enables):
  - invalid_inst: cause 2, next TRAP.
  - Otherwise next EXECUTE.
- EXECUTE, by opcode:
  - OP (0110011): sel1=0, sel2=0.
  - OP-IMM (0010011): sel1=0, sel2=1.
  - LUI (0110111): sel1=2, sel2=1.
  - AUIPC (0010111): sel1=1, sel2=1.
  - For OP, OP-IMM, LUI and AUIPC: write_rd=1, rd_sel=0, write_pc=1, next FETCH.
  - JAL (1101111) / JALR (1100111):
    - ialign: cause 0, next TRAP, no writes.
    - Else write_rd=1, rd_sel=2, write_pc=1.
  - BRANCH (1100011): sel1=0, sel2=0, write_pc=1, unless ialign, in which case cause 0 and next TRAP.
  - LOAD (0000011) / STORE (0100011): sel1=0, sel2=1, next MEM.
  - SYSTEM (1110011), f3!=0:
    - invalid_csr: cause 2, next TRAP.
    - Else write_csr=1, write_rd=1, rd_sel=3, write_pc=1.
  - SYSTEM, f3==0: cause 11, next TRAP.
  - MISC-MEM (0001111): write_pc=1 only (fence as nop).
- MEM:
  - addr_sel=1; sel1/sel2 held as in EXECUTE.
  - If mem_malign: strobes suppressed, cause 4 (load) / 6 (store), next TRAP.
  - Load: mem_read=1. On mem_complete_read: write_rd=1, rd_sel=1, write_pc=1, next FETCH.
  - Store: mem_write=1. On mem_complete_write: write_pc=1, next FETCH.
  - Watchdog expiry: cause 5 (load) / 7 (store).
- Watchdog:
  - Counter clears on entry to FETCH/MEM and increments each cycle without completion.
  - Expires when count == MEM_TIMEOUT-1 with no completion.
  - A completion in the expiry cycle wins over the timeout.
- TRAP (1 cycle): trap=1, write_pc=1 (datapath loads trap vector), no other writes, next FETCH/HALTED.
- HALTED:
  - halted=1, all enables/strobes 0.
  - resume_req=1 and halt_req=0: next FETCH.
  - Both high: stay halted.

Test Plan:
- ADD (opcode 0110011), fetch completes on cycle 2 → DECODE, EXECUTE; write_rd=1, rd_sel=0, write_pc=1 exactly once; back in FETCH 4 cycles after reset release.
- LW with mem_complete_read after 3 MEM cycles → mem_read high 3 cycles, addr_sel=1; write_rd with rd_sel=1 on the 3rd; no trap.
- SW with mem_malign=1 → mem_write never asserted; trap=1 for 1 cycle, trap_cause=6; next state FETCH.
- MEM_TIMEOUT=4, fetch never completes → trap asserted on cycle 5 after FETCH entry, trap_cause=1; complete arriving on the 4th cycle instead → no trap.
- halt_req raised mid-LW → load finishes (write_rd pulses), then halted=1 with no FETCH read. resume_req with halt_req=0 → FETCH next cycle. Both high → remains halted.
- CSRRW with invalid_csr=1 → write_csr=0, write_rd=0, trap_cause=2. ECALL (f3=0) → trap_cause=11.

Source files
------------

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle sequencer and the RV32I datapath:
// decoder/datapath status towards the sequencer, enables and selects back.
interface multicycle_control_fsm_if #(
    parameter int OPCODE_WIDTH = 7,
    parameter int F3_WIDTH     = 3
) ();
    logic [OPCODE_WIDTH-1:0] opcode;
    logic [F3_WIDTH-1:0]     f3;
    logic                    invalid_inst;
    logic                    ialign;
    logic                    invalid_csr;
    logic                    mem_malign;
    logic                    mem_complete_read;
    logic                    mem_complete_write;
    logic                    halt_req;
    logic                    resume_req;

    logic                    write_pc;
    logic                    write_ir;
    logic                    write_rd;
    logic                    write_csr;
    logic                    mem_read;
    logic                    mem_write;
    logic                    addr_sel;
    logic [1:0]              rd_sel;
    logic [1:0]              alu_insel1;
    logic [1:0]              alu_insel2;
    logic                    trap;
    logic [3:0]              trap_cause;
    logic                    halted;

    modport master (
        input  opcode, f3, invalid_inst, ialign, invalid_csr, mem_malign,
               mem_complete_read, mem_complete_write, halt_req, resume_req,
        output write_pc, write_ir, write_rd, write_csr, mem_read, mem_write,
               addr_sel, rd_sel, alu_insel1, alu_insel2, trap, trap_cause, halted
    );

    modport slave (
        output opcode, f3, invalid_inst, ialign, invalid_csr, mem_malign,
               mem_complete_read, mem_complete_write, halt_req, resume_req,
        input  write_pc, write_ir, write_rd, write_csr, mem_read, mem_write,
               addr_sel, rd_sel, alu_insel1, alu_insel2, trap, trap_cause, halted
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I control sequencer with memory watchdog, precise traps
// and a debug halt/resume handshake taken only at instruction boundaries.
module multicycle_control_fsm #(
    parameter int OPCODE_WIDTH  = 7,
    parameter int F3_WIDTH      = 3,
    parameter int MEM_TIMEOUT   = 16,
    parameter int HALT_ON_RESET = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    multicycle_control_fsm_if.master bus
);
    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_TRAP    = 3'd4,
        S_HALTED  = 3'd5
    } state_e;

    localparam int               CNT_W       = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam bit               WD_EN       = (MEM_TIMEOUT > 0);
    localparam int               CNT_LAST_I  = (MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0;
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_LAST_I[CNT_W-1:0];
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam state_e           RESET_STATE = (HALT_ON_RESET != 0) ? S_HALTED : S_FETCH;

    localparam logic [OPCODE_WIDTH-1:0] OPC_OP     = OPCODE_WIDTH'(7'b0110011);
    localparam logic [OPCODE_WIDTH-1:0] OPC_OPIMM  = OPCODE_WIDTH'(7'b0010011);
    localparam logic [OPCODE_WIDTH-1:0] OPC_LUI    = OPCODE_WIDTH'(7'b0110111);
    localparam logic [OPCODE_WIDTH-1:0] OPC_AUIPC  = OPCODE_WIDTH'(7'b0010111);
    localparam logic [OPCODE_WIDTH-1:0] OPC_JAL    = OPCODE_WIDTH'(7'b1101111);
    localparam logic [OPCODE_WIDTH-1:0] OPC_JALR   = OPCODE_WIDTH'(7'b1100111);
    localparam logic [OPCODE_WIDTH-1:0] OPC_BRANCH = OPCODE_WIDTH'(7'b1100011);
    localparam logic [OPCODE_WIDTH-1:0] OPC_LOAD   = OPCODE_WIDTH'(7'b0000011);
    localparam logic [OPCODE_WIDTH-1:0] OPC_STORE  = OPCODE_WIDTH'(7'b0100011);
    localparam logic [OPCODE_WIDTH-1:0] OPC_SYSTEM = OPCODE_WIDTH'(7'b1110011);
    localparam logic [OPCODE_WIDTH-1:0] OPC_MISC   = OPCODE_WIDTH'(7'b0001111);

    localparam logic [3:0] CAUSE_IMISALIGN = 4'd0;
    localparam logic [3:0] CAUSE_IFAULT    = 4'd1;
    localparam logic [3:0] CAUSE_ILLEGAL   = 4'd2;
    localparam logic [3:0] CAUSE_LMISALIGN = 4'd4;
    localparam logic [3:0] CAUSE_LFAULT    = 4'd5;
    localparam logic [3:0] CAUSE_SMISALIGN = 4'd6;
    localparam logic [3:0] CAUSE_SFAULT    = 4'd7;
    localparam logic [3:0] CAUSE_ECALL     = 4'd11;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       cause_q, cause_d;

    logic   is_store_s, mem_done_s, wd_expire_s, sys_ok_s, f3_zero_s;
    state_e boundary_s;

    logic       write_pc_s, write_ir_s, write_rd_s, write_csr_s;
    logic       mem_read_s, mem_write_s, addr_sel_s, trap_s, halted_s;
    logic [1:0] rd_sel_s, alu_insel1_s, alu_insel2_s;

    assign is_store_s  = (bus.opcode == OPC_STORE);
    assign mem_done_s  = is_store_s ? bus.mem_complete_write : bus.mem_complete_read;
    assign wd_expire_s = WD_EN && (cnt_q == CNT_LAST);
    assign f3_zero_s   = (bus.f3 == {F3_WIDTH{1'b0}});
    assign sys_ok_s    = !f3_zero_s && !bus.invalid_csr;
    // Any instruction boundary diverts to HALTED while debug asks for it.
    assign boundary_s  = bus.halt_req ? S_HALTED : S_FETCH;

    // State, watchdog counter and trap cause registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RESET_STATE;
            cnt_q   <= CNT_ZERO;
            cause_q <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end

    // Next-state and trap cause selection.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            S_FETCH: begin
                if (bus.mem_complete_read) begin
                    state_d = S_DECODE;
                end else if (wd_expire_s) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_IFAULT;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                if (bus.invalid_inst) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end else begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                case (bus.opcode)
                    OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC, OPC_MISC: state_d = boundary_s;
                    OPC_JAL, OPC_JALR, OPC_BRANCH: begin
                        if (bus.ialign) begin
                            state_d = S_TRAP;
                            cause_d = CAUSE_IMISALIGN;
                        end else begin
                            state_d = boundary_s;
                        end
                    end
                    OPC_LOAD, OPC_STORE: state_d = S_MEM;
                    OPC_SYSTEM: begin
                        if (f3_zero_s) begin
                            state_d = S_TRAP;
                            cause_d = CAUSE_ECALL;
                        end else if (bus.invalid_csr) begin
                            state_d = S_TRAP;
                            cause_d = CAUSE_ILLEGAL;
                        end else begin
                            state_d = boundary_s;
                        end
                    end
                    default: begin
                        state_d = S_TRAP;
                        cause_d = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_MEM: begin
                // Misalignment beats completion, completion beats the watchdog.
                if (bus.mem_malign) begin
                    state_d = S_TRAP;
                    cause_d = is_store_s ? CAUSE_SMISALIGN : CAUSE_LMISALIGN;
                end else if (mem_done_s) begin
                    state_d = boundary_s;
                end else if (wd_expire_s) begin
                    state_d = S_TRAP;
                    cause_d = is_store_s ? CAUSE_SFAULT : CAUSE_LFAULT;
                end else begin
                    state_d = S_MEM;
                end
            end
            S_TRAP: state_d = boundary_s;
            S_HALTED: begin
                if (bus.resume_req && !bus.halt_req) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_HALTED;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Watchdog: cleared on every state change, counts waiting cycles.
    always_comb begin
        if (state_d != state_q) begin
            cnt_d = CNT_ZERO;
        end else if (WD_EN && ((state_q == S_FETCH) || (state_q == S_MEM))) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Control bundle decode from state, opcode and status.
    always_comb begin
        write_pc_s   = 1'b0;
        write_ir_s   = 1'b0;
        write_rd_s   = 1'b0;
        write_csr_s  = 1'b0;
        mem_read_s   = 1'b0;
        mem_write_s  = 1'b0;
        addr_sel_s   = 1'b0;
        rd_sel_s     = 2'd0;
        alu_insel1_s = 2'd0;
        alu_insel2_s = 2'd0;
        trap_s       = 1'b0;
        halted_s     = 1'b0;
        if (rst) begin
            mem_read_s = 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    mem_read_s = 1'b1;
                    write_ir_s = bus.mem_complete_read;
                end
                S_EXECUTE: begin
                    case (bus.opcode)
                        OPC_OP: begin
                            write_rd_s = 1'b1;
                            write_pc_s = 1'b1;
                        end
                        OPC_OPIMM: begin
                            alu_insel2_s = 2'd1;
                            write_rd_s   = 1'b1;
                            write_pc_s   = 1'b1;
                        end
                        OPC_LUI: begin
                            alu_insel1_s = 2'd2;
                            alu_insel2_s = 2'd1;
                            write_rd_s   = 1'b1;
                            write_pc_s   = 1'b1;
                        end
                        OPC_AUIPC, OPC_JAL: begin
                            alu_insel1_s = 2'd1;
                            alu_insel2_s = 2'd1;
                            write_rd_s   = (bus.opcode == OPC_AUIPC) || !bus.ialign;
                            write_pc_s   = (bus.opcode == OPC_AUIPC) || !bus.ialign;
                            rd_sel_s     = (bus.opcode == OPC_JAL) ? 2'd2 : 2'd0;
                        end
                        OPC_JALR: begin
                            alu_insel2_s = 2'd1;
                            rd_sel_s     = 2'd2;
                            write_rd_s   = !bus.ialign;
                            write_pc_s   = !bus.ialign;
                        end
                        OPC_BRANCH: write_pc_s = !bus.ialign;
                        OPC_LOAD, OPC_STORE: alu_insel2_s = 2'd1;
                        OPC_SYSTEM: begin
                            rd_sel_s    = 2'd3;
                            write_csr_s = sys_ok_s;
                            write_rd_s  = sys_ok_s;
                            write_pc_s  = sys_ok_s;
                        end
                        OPC_MISC: write_pc_s = 1'b1;
                        default: write_pc_s = 1'b0;
                    endcase
                end
                S_MEM: begin
                    addr_sel_s   = 1'b1;
                    alu_insel2_s = 2'd1;
                    rd_sel_s     = 2'd1;
                    mem_read_s   = !is_store_s && !bus.mem_malign;
                    mem_write_s  = is_store_s && !bus.mem_malign;
                    write_rd_s   = !is_store_s && !bus.mem_malign && bus.mem_complete_read;
                    write_pc_s   = !bus.mem_malign && mem_done_s;
                end
                S_TRAP: begin
                    trap_s     = 1'b1;
                    write_pc_s = 1'b1;
                end
                S_HALTED: halted_s = 1'b1;
                default: trap_s = 1'b0;
            endcase
        end
    end

    assign bus.write_pc   = write_pc_s;
    assign bus.write_ir   = write_ir_s;
    assign bus.write_rd   = write_rd_s;
    assign bus.write_csr  = write_csr_s;
    assign bus.mem_read   = mem_read_s;
    assign bus.mem_write  = mem_write_s;
    assign bus.addr_sel   = addr_sel_s;
    assign bus.rd_sel     = rd_sel_s;
    assign bus.alu_insel1 = alu_insel1_s;
    assign bus.alu_insel2 = alu_insel2_s;
    assign bus.trap       = trap_s;
    assign bus.trap_cause = cause_q;
    assign bus.halted     = halted_s;
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Cycle-table bench for multicycle_control_fsm (MEM_TIMEOUT=4) with a
// scoreboard queue and a hand-written bounded fetch-timeout sequence.
module tb_multicycle_control_fsm;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multicycle_control_fsm_if #(.OPCODE_WIDTH(7), .F3_WIDTH(3)) bus ();

    multicycle_control_fsm #(
        .OPCODE_WIDTH(7), .F3_WIDTH(3), .MEM_TIMEOUT(4), .HALT_ON_RESET(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    localparam logic [6:0] OP   = 7'b0110011, OPI = 7'b0010011, LUI = 7'b0110111;
    localparam logic [6:0] AUI  = 7'b0010111, JAL = 7'b1101111, JALR = 7'b1100111;
    localparam logic [6:0] BR   = 7'b1100011, LD  = 7'b0000011, ST   = 7'b0100011;
    localparam logic [6:0] SYS  = 7'b1110011, FEN = 7'b0001111;

    localparam logic [7:0] F_INV = 8'h80, F_IAL = 8'h40, F_CSR = 8'h20, F_MAL = 8'h10;
    localparam logic [7:0] F_CR  = 8'h08, F_CW  = 8'h04, F_HLT = 8'h02, F_RES = 8'h01;

    typedef struct packed {
        logic       rst;
        logic [6:0] opc;
        logic [2:0] f3;
        logic       inv, ial, icsr, malign, cr, cw, hreq, rreq;
    } ins_t;

    typedef struct packed {
        logic       wpc, wir, wrd, wcsr, mrd, mwr, asel;
        logic [1:0] rdsel, s1, s2;
        logic       trap;
        logic [3:0] cause;
        logic       halted;
    } outs_t;

    typedef struct {
        string name;
        ins_t  i;
        outs_t e;
        outs_t m;
    } vec_t;

    typedef struct {
        string name;
        outs_t e;
        outs_t m;
    } exp_t;

    vec_t  vecs[$];
    exp_t  exp_q[$];
    int    total = 0;
    int    bad   = 0;
    outs_t MK_CTL, MK_TRAP, MK_EX, MK_EXN;

    function automatic outs_t msk(input logic sels, input logic rdsel, input logic cause);
        outs_t m;
        m = '1;
        if (!sels) begin
            m.s1 = 2'b00;
            m.s2 = 2'b00;
        end
        if (!rdsel) m.rdsel = 2'b00;
        if (!cause) m.cause = 4'h0;
        return m;
    endfunction

    function automatic outs_t e_fetch(input logic cr);
        outs_t o;
        o = '0;
        o.mrd = 1'b1;
        o.wir = cr;
        return o;
    endfunction

    function automatic outs_t e_exec(input logic wpc, input logic wrd, input logic wcsr,
                                     input logic [1:0] rdsel, input logic [1:0] s1,
                                     input logic [1:0] s2);
        outs_t o;
        o = '0;
        o.wpc = wpc;
        o.wrd = wrd;
        o.wcsr = wcsr;
        o.rdsel = rdsel;
        o.s1 = s1;
        o.s2 = s2;
        return o;
    endfunction

    function automatic outs_t e_mem(input logic load, input logic done);
        outs_t o;
        o = '0;
        o.asel = 1'b1;
        o.s2 = 2'd1;
        o.mrd = load;
        o.mwr = !load;
        o.wrd = load && done;
        o.rdsel = load ? 2'd1 : 2'd0;
        o.wpc = done;
        return o;
    endfunction

    function automatic outs_t e_mal();
        outs_t o;
        o = '0;
        o.asel = 1'b1;
        o.s2 = 2'd1;
        return o;
    endfunction

    function automatic outs_t e_trap(input logic [3:0] cause);
        outs_t o;
        o = '0;
        o.trap = 1'b1;
        o.wpc = 1'b1;
        o.cause = cause;
        return o;
    endfunction

    function automatic outs_t e_halt();
        outs_t o;
        o = '0;
        o.halted = 1'b1;
        return o;
    endfunction

    task automatic add(input string name, input logic r, input logic [6:0] op,
                       input logic [2:0] f, input logic [7:0] fl, input outs_t e, input outs_t m);
        vec_t v;
        v.name = name;
        v.i = ins_t'({r, op, f, fl});
        v.e = e;
        v.m = m;
        vecs.push_back(v);
    endtask

    // Completed fetch of the given instruction followed by its decode cycle.
    task automatic fd(input logic [6:0] op, input logic [2:0] f, input logic [7:0] dfl);
        add("fetch_done", 1'b0, op, f, F_CR, e_fetch(1'b1), MK_CTL);
        add("decode", 1'b0, op, f, dfl, outs_t'('0), MK_CTL);
    endtask

    task automatic drive(input ins_t i);
        rst = i.rst;
        bus.opcode = i.opc;
        bus.f3 = i.f3;
        bus.invalid_inst = i.inv;
        bus.ialign = i.ial;
        bus.invalid_csr = i.icsr;
        bus.mem_malign = i.malign;
        bus.mem_complete_read = i.cr;
        bus.mem_complete_write = i.cw;
        bus.halt_req = i.hreq;
        bus.resume_req = i.rreq;
    endtask

    function automatic outs_t sample();
        outs_t o;
        o.wpc = bus.write_pc;
        o.wir = bus.write_ir;
        o.wrd = bus.write_rd;
        o.wcsr = bus.write_csr;
        o.mrd = bus.mem_read;
        o.mwr = bus.mem_write;
        o.asel = bus.addr_sel;
        o.rdsel = bus.rd_sel;
        o.s1 = bus.alu_insel1;
        o.s2 = bus.alu_insel2;
        o.trap = bus.trap;
        o.cause = bus.trap_cause;
        o.halted = bus.halted;
        return o;
    endfunction

    task automatic check(input string name, input outs_t e, input outs_t m);
        outs_t a;
        a = sample();
        total++;
        if (((a ^ e) & m) != '0) begin
            bad++;
            $display("FAIL %s: got %h required %h (care mask %h)", name, a, e, m);
        end
    endtask

    initial begin
        exp_t x;
        int   cyc;
        drive(ins_t'({1'b1, OP, 3'd0, 8'h00}));
        MK_CTL  = msk(1'b0, 1'b0, 1'b0);
        MK_TRAP = msk(1'b0, 1'b0, 1'b1);
        MK_EX   = msk(1'b1, 1'b1, 1'b0);
        MK_EXN  = msk(1'b1, 1'b0, 1'b0);

        add("reset0", 1'b1, OP, 3'd0, 8'h00, outs_t'('0), MK_EX);
        add("reset1", 1'b1, OP, 3'd0, 8'h00, outs_t'('0), MK_EX);
        add("fetch_wait_cause0", 1'b0, OP, 3'd0, 8'h00, e_fetch(1'b0), MK_TRAP);
        fd(OP, 3'd0, 8'h00);
        add("exec_add", 1'b0, OP, 3'd0, 8'h00, e_exec(1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0), MK_EX);
        fd(LD, 3'd2, 8'h00);
        add("exec_lw", 1'b0, LD, 3'd2, 8'h00, e_exec(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd1), MK_EXN);
        add("lw_mem1", 1'b0, LD, 3'd2, 8'h00, e_mem(1'b1, 1'b0), MK_EXN);
        add("lw_mem2", 1'b0, LD, 3'd2, 8'h00, e_mem(1'b1, 1'b0), MK_EXN);
        add("lw_mem3_done", 1'b0, LD, 3'd2, F_CR, e_mem(1'b1, 1'b1), MK_EX);
        fd(ST, 3'd2, 8'h00);
        add("exec_sw", 1'b0, ST, 3'd2, 8'h00, e_exec(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd1), MK_EXN);
        add("sw_malign", 1'b0, ST, 3'd2, F_MAL, e_mal(), MK_EXN);
        add("trap_sw_malign", 1'b0, ST, 3'd2, 8'h00, e_trap(4'd6), MK_TRAP);
        for (int k = 0; k < 4; k++) add("ifetch_stall", 1'b0, OPI, 3'd0, 8'h00, e_fetch(1'b0), MK_CTL);
        add("trap_ifetch_timeout", 1'b0, OPI, 3'd0, 8'h00, e_trap(4'd1), MK_TRAP);
        for (int k = 0; k < 3; k++) add("fetch_slow", 1'b0, OPI, 3'd0, 8'h00, e_fetch(1'b0), MK_CTL);
        add("fetch_done_last_cycle", 1'b0, OPI, 3'd0, F_CR, e_fetch(1'b1), MK_CTL);
        add("decode_no_trap", 1'b0, OPI, 3'd0, 8'h00, outs_t'('0), MK_CTL);
        add("exec_addi", 1'b0, OPI, 3'd0, 8'h00, e_exec(1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 2'd1), MK_EX);
        fd(LD, 3'd2, 8'h00);
        add("exec_lw", 1'b0, LD, 3'd2, 8'h00, e_exec(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd1), MK_EXN);
        for (int k = 0; k < 4; k++) add("lw_mem_stall", 1'b0, LD, 3'd2, 8'h00, e_mem(1'b1, 1'b0), MK_EXN);
        add("trap_load_timeout", 1'b0, LD, 3'd2, 8'h00, e_trap(4'd5), MK_TRAP);
        fd(LD, 3'd2, 8'h00);
        add("exec_lw", 1'b0, LD, 3'd2, 8'h00, e_exec(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd1), MK_EXN);
        add("lw_mem_halt_req", 1'b0, LD, 3'd2, F_HLT, e_mem(1'b1, 1'b0), MK_EXN);
        add("lw_done_halt_req", 1'b0, LD, 3'd2, F_CR | F_HLT, e_mem(1'b1, 1'b1), MK_EX);
        add("halted_both_req", 1'b0, LD, 3'd2, F_HLT | F_RES, e_halt(), MK_CTL);
        add("halted_resume", 1'b0, LD, 3'd2, F_RES, e_halt(), MK_CTL);
        add("fetch_after_resume", 1'b0, SYS, 3'd1, 8'h00, e_fetch(1'b0), MK_CTL);
        fd(SYS, 3'd1, 8'h00);
        add("exec_csrrw_bad", 1'b0, SYS, 3'd1, F_CSR, outs_t'('0), MK_CTL);
        add("trap_bad_csr", 1'b0, SYS, 3'd1, 8'h00, e_trap(4'd2), MK_TRAP);
        fd(SYS, 3'd0, 8'h00);
        add("exec_ecall", 1'b0, SYS, 3'd0, 8'h00, outs_t'('0), MK_CTL);
        add("trap_ecall", 1'b0, SYS, 3'd0, 8'h00, e_trap(4'd11), MK_TRAP);
        fd(SYS, 3'd1, 8'h00);
        add("exec_csrrw", 1'b0, SYS, 3'd1, 8'h00, e_exec(1'b1, 1'b1, 1'b1, 2'd3, 2'd0, 2'd0),
            msk(1'b0, 1'b1, 1'b0));
        fd(OP, 3'd0, F_INV);
        add("trap_illegal", 1'b0, OP, 3'd0, 8'h00, e_trap(4'd2), MK_TRAP);
        fd(JAL, 3'd0, 8'h00);
        add("exec_jal_misalign", 1'b0, JAL, 3'd0, F_IAL, outs_t'('0), MK_CTL);
        add("trap_jal_misalign", 1'b0, JAL, 3'd0, 8'h00, e_trap(4'd0), MK_TRAP);
        fd(BR, 3'd0, 8'h00);
        add("exec_branch", 1'b0, BR, 3'd0, 8'h00, e_exec(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0), MK_EXN);
        fd(JALR, 3'd0, 8'h00);
        add("exec_jalr", 1'b0, JALR, 3'd0, 8'h00, e_exec(1'b1, 1'b1, 1'b0, 2'd2, 2'd0, 2'd0),
            msk(1'b0, 1'b1, 1'b0));
        fd(LUI, 3'd0, 8'h00);
        add("exec_lui", 1'b0, LUI, 3'd0, 8'h00, e_exec(1'b1, 1'b1, 1'b0, 2'd0, 2'd2, 2'd1), MK_EX);
        fd(AUI, 3'd0, 8'h00);
        add("exec_auipc", 1'b0, AUI, 3'd0, 8'h00, e_exec(1'b1, 1'b1, 1'b0, 2'd0, 2'd1, 2'd1), MK_EX);
        fd(FEN, 3'd0, 8'h00);
        add("exec_fence", 1'b0, FEN, 3'd0, 8'h00, e_exec(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0), MK_CTL);
        fd(ST, 3'd2, 8'h00);
        add("exec_sw", 1'b0, ST, 3'd2, 8'h00, e_exec(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd1), MK_EXN);
        add("sw_mem_wait", 1'b0, ST, 3'd2, 8'h00, e_mem(1'b0, 1'b0), MK_EXN);
        add("sw_mem_done", 1'b0, ST, 3'd2, F_CW, e_mem(1'b0, 1'b1), MK_EXN);
        fd(ST, 3'd2, 8'h00);
        add("exec_sw", 1'b0, ST, 3'd2, 8'h00, e_exec(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd1), MK_EXN);
        for (int k = 0; k < 4; k++) add("sw_mem_stall", 1'b0, ST, 3'd2, 8'h00, e_mem(1'b0, 1'b0), MK_EXN);
        add("trap_store_timeout", 1'b0, ST, 3'd2, F_HLT, e_trap(4'd7), MK_TRAP);
        add("halted_after_trap", 1'b0, LD, 3'd2, F_RES, e_halt(), MK_CTL);
        fd(LD, 3'd2, 8'h00);
        add("exec_lw", 1'b0, LD, 3'd2, 8'h00, e_exec(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd1), MK_EXN);
        add("lw_mem_reset_drop", 1'b1, LD, 3'd2, F_CR, outs_t'('0), MK_EX);
        add("fetch_after_reset_cause0", 1'b0, LD, 3'd2, 8'h00, e_fetch(1'b0), MK_TRAP);

        for (int k = 0; k < vecs.size(); k++) begin
            @(posedge clk);
            #1;
            drive(vecs[k].i);
            exp_q.push_back('{vecs[k].name, vecs[k].e, vecs[k].m});
            @(negedge clk);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL scoreboard: queue empty at vector %0d", k);
            end else begin
                x = exp_q.pop_front();
                check(x.name, x.e, x.m);
            end
        end

        // Fetch that never completes: trap expected in the 5th cycle after FETCH entry.
        @(posedge clk);
        #1;
        drive(ins_t'({1'b1, OP, 3'd0, 8'h00}));
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 1;
        while (cyc <= 20) begin
            @(negedge clk);
            if (bus.trap) break;
            @(posedge clk);
            #1;
            cyc++;
        end
        total++;
        if (cyc != 5) begin
            bad++;
            $display("FAIL fetch_timeout_cycle: trap seen at cycle %0d, required 5", cyc);
        end
        total++;
        if (bus.trap_cause != 4'd1) begin
            bad++;
            $display("FAIL fetch_timeout_cause: got %0d required 1", bus.trap_cause);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
